// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one UART transmitter (start/data/done interface) between NUM_REQ
//   byte producers. Arbitration is work-conserving round-robin, and each grant
//   accepts one byte through a valid/ready handshake. The accepted byte is
//   launched on the transmitter. The arbiter then waits for the transmitter's
//   completion pulse before it arbitrates again.
//
// Parameters:
//   NUM_REQ  number of requesters (>= 2)
//   WIDTH    data bits per character, same as the transmitter WIDTH
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   req_valid  in   [NUM_REQ]        per-requester byte available
//   req_data   in   [NUM_REQ*WIDTH]  requester i byte at [i*WIDTH +: WIDTH]
//   req_lock   in   [NUM_REQ]        keep grant after this byte (lock build only)
//   req_ready  out  [NUM_REQ]        one-hot accept strobe
//   tx_start   out  one-cycle launch pulse to the transmitter
//   tx_data    out  [WIDTH] byte to transmit, stable from tx_start to tx_done
//   tx_done    in   one-cycle completion pulse from the transmitter
//   grant_id   out  index of the requester that owns the current byte
//   busy       out  high whenever the FSM is not in IDLE
//
// Handshake:
//   A byte transfers from requester i on a rising edge where req_valid[i] and
//   req_ready[i] are both high. req_ready is driven only in IDLE, only to the
//   arbitration winner, and never to a requester whose req_valid is low. A
//   requester may drop req_valid at any time before it is granted.
//
// Configuration:
//   `define UART_ARB_LOCK_EN enables grant locking. The req_lock bit of the
//   winner is captured with its byte. While that bit is set, only the holder
//   can be granted again. The lock releases when the holder sends a byte with
//   req_lock low. Without the macro, req_lock is ignored.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_lock,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     tx_start,
  output logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_done,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            found;

`ifdef UART_ARB_LOCK_EN
  logic            lock_hold;
`else
  logic            unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Round-robin search. Candidates are rr_ptr+1, rr_ptr+2, ... and wrap
  // modulo NUM_REQ. The search uses integer arithmetic so that a count that
  // is not a power of two never reaches an unused index code.
  always_comb begin
    int cand;
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = ID_W'(cand);
      end
    end
`ifdef UART_ARB_LOCK_EN
    // A locked holder is the only candidate. If it drops valid, the arbiter
    // waits for it.
    if (lock_hold) begin
      found  = req_valid[grant_id];
      winner = grant_id;
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock_hold <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (found) begin
            tx_data  <= req_data[int'(winner)*WIDTH +: WIDTH];
            grant_id <= winner;
            rr_ptr   <= winner;
`ifdef UART_ARB_LOCK_EN
            lock_hold <= req_lock[winner];
            // The pointer stays frozen while the lock continues. When the
            // holder releases, round-robin resumes after the holder.
            if (lock_hold && req_lock[winner]) begin
              rr_ptr <= rr_ptr;
            end
`endif
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          // A tx_done seen here is treated as stale and ignored.
          tx_start <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          tx_start <= 1'b0;
          if (tx_done) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
